// File: rtl/microcode_pkg.sv
// Shared definitions for the microcode RAM arbiter: owner encoding, defaults,
// and the port identifier used by the round-robin pick.
package microcode_pkg;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_P0   = 2'b01;
    localparam logic [1:0] OWN_P1   = 2'b10;

    localparam int DEF_AW    = 8;
    localparam int DEF_DW    = 32;
    localparam int RAM_DEPTH = 256;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    function automatic logic [1:0] port_to_owner(input port_e p);
        return (p == PORT1) ? OWN_P1 : OWN_P0;
    endfunction

endpackage

// File: rtl/microcode_ram_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: on a tie the port that did not
// win last time is chosen.
module rr_pick2
    import microcode_pkg::*;
(
    input  logic  i_req0,
    input  logic  i_req1,
    input  port_e i_last,
    output logic  o_valid,
    output port_e o_winner
);

    // Tie goes to the port that was not last served
    always_comb begin
        o_valid  = i_req0 | i_req1;
        o_winner = PORT0;
        if (i_req0 && i_req1) begin
            o_winner = (i_last == PORT0) ? PORT1 : PORT0;
        end else if (i_req1) begin
            o_winner = PORT1;
        end else begin
            o_winner = PORT0;
        end
    end

endmodule

// File: rtl/microcode_ram_arbiter.sv
// Two-port arbiter in front of a single-port microcode RAM: round-robin with
// optional locked bursts capped at MAX_BURST beats, one access per cycle.
module microcode_ram_arbiter
    import microcode_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic [1:0]    owner,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int              BCW       = $clog2(MAX_BURST) + 1;
    localparam logic [BCW-1:0]  BURST_MAX = BCW'(MAX_BURST);

    logic [1:0]     r_owner;
    port_e          r_last;
    logic [BCW-1:0] r_beat_cnt;
    logic           r_rvalid0;
    logic           r_rvalid1;

    logic  w_pick_valid;
    port_e w_pick;
    logic  w_req_own;
    logic  w_lock_own;
    logic  w_cont;
    logic  w_sel_valid;
    port_e w_sel;
    logic  w_lock_sel;

    rr_pick2 u_pick (
        .i_req0   (req0),
        .i_req1   (req1),
        .i_last   (r_last),
        .o_valid  (w_pick_valid),
        .o_winner (w_pick)
    );

    // Winner select: an unexpired locked burst overrides round-robin
    always_comb begin
        w_req_own  = 1'b0;
        w_lock_own = 1'b0;
        case (r_owner)
            OWN_P0: begin
                w_req_own  = req0;
                w_lock_own = lock0;
            end
            OWN_P1: begin
                w_req_own  = req1;
                w_lock_own = lock1;
            end
            default: begin
                w_req_own  = 1'b0;
                w_lock_own = 1'b0;
            end
        endcase
        w_cont = (r_owner != OWN_NONE) && w_req_own && w_lock_own && (r_beat_cnt < BURST_MAX);

        if (RST) begin
            w_sel_valid = 1'b0;
            w_sel       = PORT0;
        end else if (w_cont) begin
            w_sel_valid = 1'b1;
            w_sel       = (r_owner == OWN_P1) ? PORT1 : PORT0;
        end else begin
            w_sel_valid = w_pick_valid;
            w_sel       = w_pick;
        end
    end

    // Grant and RAM request mux; RAM signals are zero when idle
    always_comb begin
        gnt0      = w_sel_valid && (w_sel == PORT0);
        gnt1      = w_sel_valid && (w_sel == PORT1);
        ram_en    = w_sel_valid;
        if (gnt1) begin
            ram_we     = we1;
            ram_addr   = addr1;
            ram_wdata  = wdata1;
            w_lock_sel = lock1;
        end else if (gnt0) begin
            ram_we     = we0;
            ram_addr   = addr0;
            ram_wdata  = wdata0;
            w_lock_sel = lock0;
        end else begin
            ram_we     = 1'b0;
            ram_addr   = {AW{1'b0}};
            ram_wdata  = {DW{1'b0}};
            w_lock_sel = 1'b0;
        end
    end

    // Ownership, round-robin history, burst counter and read-valid pipeline
    always_ff @(posedge clk) begin
        if (RST) begin
            r_owner    <= OWN_NONE;
            r_last     <= PORT1;
            r_beat_cnt <= {BCW{1'b0}};
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
        end else begin
            r_rvalid0 <= gnt0 & ~we0;
            r_rvalid1 <= gnt1 & ~we1;
            if (w_sel_valid) begin
                r_last     <= w_sel;
                r_beat_cnt <= w_cont ? (r_beat_cnt + {{(BCW-1){1'b0}}, 1'b1}) : {{(BCW-1){1'b0}}, 1'b1};
                r_owner    <= w_lock_sel ? port_to_owner(w_sel) : OWN_NONE;
            end else begin
                r_owner    <= OWN_NONE;
                r_beat_cnt <= {BCW{1'b0}};
            end
        end
    end

    assign owner   = r_owner;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata   = ram_rdata;

endmodule

// File: tb/tb_microcode_ram_arbiter.sv
// Self-checking bench for microcode_ram_arbiter: directed scenarios plus a
// randomized run checked against a behavioural arbitration/memory model.
module tb_microcode_ram_arbiter;

    localparam int AW        = 8;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;

    logic          clk;
    logic          RST;
    logic          req0, req1, lock0, lock1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic [1:0]    owner;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int n_tests;
    int n_fail;

    microcode_ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .RST(RST),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .owner(owner),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM macro model: untouched words read as their power-up pattern
    bit [DW-1:0] mem     [0:255];
    bit          mem_wr  [0:255];
    function automatic logic [DW-1:0] init_val(input int a);
        return (a == 5) ? 32'hDEADBEEF : 32'(a);
    endfunction
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr]    <= ram_wdata;
                mem_wr[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= mem_wr[ram_addr] ? mem[ram_addr] : init_val(int'(ram_addr));
            end
        end
    end

    // Reference model: -1 = nobody, 0/1 = port index
    int          m_owner;
    int          m_last;
    int          m_beats;
    bit          m_cont;
    logic [DW-1:0] shadow [0:255];

    function automatic int model_pick(input bit r0, input bit r1, input bit l0, input bit l1);
        bit holds;
        holds  = (m_owner == 0) ? (r0 && l0) : (m_owner == 1) ? (r1 && l1) : 1'b0;
        m_cont = holds && (m_beats < MAX_BURST);
        if (m_cont)    return m_owner;
        if (r0 && r1)  return 1 - m_last;
        if (r0)        return 0;
        if (r1)        return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_beats = 0;
        m_cont  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        we0 = 1'b0; we1 = 1'b0; addr0 = 8'h00; addr1 = 8'h00;
        wdata0 = 32'h0; wdata1 = 32'h0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1'b1;
        tick();
        req0 = 1'b1; addr0 = 8'h01;
        for (int i = 0; i < 3; i++) begin
            #4;
            n_tests++;
            if (gnt0 !== 1'b0 || ram_en !== 1'b0 || owner !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: gnt0=%b ram_en=%b owner=%b, want 0 0 00", i, gnt0, ram_en, owner);
            end
            tick();
        end
        RST = 1'b0;
        #4;
        n_tests++;
        if (gnt0 !== 1'b1 || ram_en !== 1'b1 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: gnt0=%b ram_en=%b rv=%b%b, want 1 1 00", gnt0, ram_en, rvalid0, rvalid1);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_single_read();
        reset_dut();
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h05;
        #4;
        n_tests++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || ram_addr !== 8'h05 || ram_we !== 1'b0 || rvalid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read_grant: gnt1=%b gnt0=%b addr=%h we=%b rv0=%b, want 1 0 05 0 0", gnt1, gnt0, ram_addr, ram_we, rvalid0);
        end
        tick();
        req1 = 1'b0;
        #4;
        n_tests++;
        if (rvalid1 !== 1'b1 || rdata !== 32'hDEADBEEF || rvalid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read_data: rv1=%b rdata=%h rv0=%b, want 1 deadbeef 0", rvalid1, rdata, rvalid0);
        end
        tick();
    endtask

    task automatic test_tie();
        reset_dut();
        req0 = 1'b1; req1 = 1'b1; addr0 = 8'h01; addr1 = 8'h02;
        for (int i = 0; i < 4; i++) begin
            #4;
            n_tests++;
            if (gnt0 !== ((i % 2) == 0) || gnt1 !== ((i % 2) == 1)) begin
                n_fail++;
                $display("FAIL tie cyc%0d: gnt0=%b gnt1=%b, want %b %b", i, gnt0, gnt1, (i % 2) == 0, (i % 2) == 1);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_locked_burst();
        int exp_port [6] = '{0, 0, 0, 0, 1, 0};
        logic [AW-1:0] next_addr;
        reset_dut();
        next_addr = 8'h00;
        req0 = 1'b1; lock0 = 1'b1; we0 = 1'b1; addr0 = next_addr; wdata0 = 32'hA000_0000;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
        for (int i = 0; i < 6; i++) begin
            #4;
            n_tests++;
            if (exp_port[i] == 0) begin
                if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || ram_addr !== next_addr || ram_we !== 1'b1) begin
                    n_fail++;
                    $display("FAIL burst_p0 cyc%0d: gnt0=%b gnt1=%b addr=%h we=%b, want 1 0 %h 1", i, gnt0, gnt1, ram_addr, ram_we, next_addr);
                end
            end else begin
                if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || ram_addr !== 8'h20) begin
                    n_fail++;
                    $display("FAIL burst_p1 cyc%0d: gnt1=%b gnt0=%b addr=%h, want 1 0 20", i, gnt1, gnt0, ram_addr);
                end
            end
            if (i >= 1) begin
                n_tests++;
                if (owner !== ((i == 5) ? 2'b00 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL burst_owner cyc%0d: owner=%b, want %b", i, owner, (i == 5) ? 2'b00 : 2'b01);
                end
            end
            tick();
            if (exp_port[i] == 0) begin
                next_addr = next_addr + 8'h01;
                addr0     = next_addr;
                wdata0    = 32'hA000_0000 + 32'(next_addr);
            end else begin
                req1 = 1'b0;
            end
        end
        clear_inputs();
    endtask

    task automatic test_write_read();
        reset_dut();
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 32'h12345678;
        #4;
        n_tests++;
        if (gnt0 !== 1'b1 || ram_we !== 1'b1 || ram_wdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL wr_grant: gnt0=%b we=%b wdata=%h, want 1 1 12345678", gnt0, ram_we, ram_wdata);
        end
        tick();
        clear_inputs();
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
        #4;
        n_tests++;
        if (gnt1 !== 1'b1 || rvalid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_grant: gnt1=%b rv0=%b, want 1 0", gnt1, rvalid0);
        end
        tick();
        req1 = 1'b0;
        #4;
        n_tests++;
        if (rvalid1 !== 1'b1 || rdata !== 32'h12345678) begin
            n_fail++;
            $display("FAIL wr_then_rd: rv1=%b rdata=%h, want 1 12345678", rvalid1, rdata);
        end
        tick();
    endtask

    task automatic test_mid_burst_release();
        int exp_port [7] = '{1, 1, 0, 0, 0, 0, 1};
        reset_dut();
        req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 8'h30;
        for (int i = 0; i < 7; i++) begin
            if (i == 1) begin
                req0 = 1'b1; lock0 = 1'b1; we0 = 1'b0; addr0 = 8'h40;
            end
            if (i == 2) lock1 = 1'b0;
            #4;
            n_tests++;
            if (gnt0 !== (exp_port[i] == 0) || gnt1 !== (exp_port[i] == 1) || ram_en !== 1'b1) begin
                n_fail++;
                $display("FAIL release cyc%0d: gnt0=%b gnt1=%b ram_en=%b, want port%0d", i, gnt0, gnt1, ram_en, exp_port[i]);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_random();
        int  s;
        int  wait0, wait1;
        bit  exp_rv0, exp_rv1;
        logic [DW-1:0] exp_rd;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wd;
        bit  exp_we, exp_lock;
        logic [1:0] exp_owner;
        reset_dut();
        for (int a = 0; a < 256; a++) shadow[a] = mem_wr[a] ? mem[a] : init_val(a);
        wait0 = 0; wait1 = 0; exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rd = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!req0 && $urandom_range(0, 3) != 0) begin
                req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
                addr0 = 8'($urandom_range(0, 15)); wdata0 = $urandom;
            end
            if (!req1 && $urandom_range(0, 3) != 0) begin
                req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
                addr1 = 8'($urandom_range(0, 15)); wdata1 = $urandom;
            end
            lock0 = 1'($urandom_range(0, 3) != 0);
            lock1 = 1'($urandom_range(0, 3) != 0);
            #4;
            s = model_pick(req0, req1, lock0, lock1);
            exp_we   = (s == 0) ? we0    : (s == 1) ? we1    : 1'b0;
            exp_addr = (s == 0) ? addr0  : (s == 1) ? addr1  : 8'h00;
            exp_wd   = (s == 0) ? wdata0 : (s == 1) ? wdata1 : 32'h0;
            exp_lock = (s == 0) ? lock0  : (s == 1) ? lock1  : 1'b0;
            exp_owner = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
            n_tests++;
            if (gnt0 !== (s == 0) || gnt1 !== (s == 1) || ram_en !== (s >= 0) ||
                ram_we !== exp_we || ram_addr !== exp_addr || ram_wdata !== exp_wd) begin
                n_fail++;
                $display("FAIL rand_grant cyc%0d: gnt=%b%b en=%b we=%b addr=%h wd=%h, want port%0d we=%b addr=%h wd=%h",
                         cyc, gnt1, gnt0, ram_en, ram_we, ram_addr, ram_wdata, s, exp_we, exp_addr, exp_wd);
            end
            n_tests++;
            if (rvalid0 !== exp_rv0 || rvalid1 !== exp_rv1 || owner !== exp_owner ||
                ((exp_rv0 || exp_rv1) && rdata !== exp_rd)) begin
                n_fail++;
                $display("FAIL rand_regs cyc%0d: rv=%b%b owner=%b rdata=%h, want rv=%b%b owner=%b rdata=%h",
                         cyc, rvalid1, rvalid0, owner, rdata, exp_rv1, exp_rv0, exp_owner, exp_rd);
            end
            wait0 = (req0 && s != 0) ? wait0 + 1 : 0;
            wait1 = (req1 && s != 1) ? wait1 + 1 : 0;
            n_tests++;
            if (wait0 > MAX_BURST || wait1 > MAX_BURST) begin
                n_fail++;
                $display("FAIL rand_starve cyc%0d: wait0=%0d wait1=%0d, want <= %0d", cyc, wait0, wait1, MAX_BURST);
            end
            exp_rv0 = (s == 0) && !exp_we;
            exp_rv1 = (s == 1) && !exp_we;
            if (s >= 0) begin
                if (exp_we) shadow[exp_addr] = exp_wd;
                else        exp_rd = shadow[exp_addr];
                m_beats = m_cont ? m_beats + 1 : 1;
                m_owner = exp_lock ? s : -1;
                m_last  = s;
            end else begin
                m_owner = -1;
                m_beats = 0;
            end
            tick();
            if (s == 0) req0 = 1'b0;
            if (s == 1) req1 = 1'b0;
        end
        clear_inputs();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST     = 1'b1;
        clear_inputs();
        model_reset();
        test_reset();
        test_single_read();
        test_tie();
        test_locked_burst();
        test_write_read();
        test_mid_burst_release();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
